// File: rtl/pacman_sprite_drawer_pkg.sv
// Shared constants, state encoding and pixel helpers for the Pac-Man sprite drawer.
package pacman_sprite_drawer_pkg;

    localparam int unsigned TILE_SIZE  = 5;
    localparam int unsigned MAX_TILE_X = 31;
    localparam int unsigned MAX_TILE_Y = 23;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned COLOUR_W   = 3;
    localparam int unsigned SHAPE_W    = TILE_SIZE * TILE_SIZE;
    localparam int unsigned SCAN_W     = 3;
    localparam int unsigned PIX_W      = 9;
    localparam int unsigned IDX_W      = 5;

    localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ERASE  = 2'd1;
    localparam logic [1:0] ST_DRAW   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Pixel coordinate of a tile offset, widened so the largest valid tile cannot wrap.
    function automatic logic [PIX_W-1:0] pixel_coord(input logic [X_W-1:0] tile,
                                                     input logic [SCAN_W-1:0] off);
        return PIX_W'(tile) * PIX_W'(TILE_SIZE) + PIX_W'(off);
    endfunction

    function automatic logic [IDX_W-1:0] shape_index(input logic [SCAN_W-1:0] row,
                                                     input logic [SCAN_W-1:0] col);
        return IDX_W'(row) * IDX_W'(TILE_SIZE) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/pacman_sprite_drawer_scan.sv
// Row-major 5x5 scanner: col is the inner index, last flags the final pixel.
module tile_scan_counter
    import pacman_sprite_drawer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [SCAN_W-1:0] row,
    output logic [SCAN_W-1:0] col,
    output logic              last
);

    localparam logic [SCAN_W-1:0] LAST_IDX = SCAN_W'(TILE_SIZE - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (enable) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= (row == LAST_IDX) ? '0 : row + SCAN_W'(1);
            end else begin
                col <= col + SCAN_W'(1);
            end
        end
    end

    assign last = (row == LAST_IDX) && (col == LAST_IDX);

endmodule

// File: rtl/pacman_sprite_drawer.sv
// Draws a 5x5 sprite at a tile position, erasing the previous tile first when it moved.
module pacman_sprite_drawer
    import pacman_sprite_drawer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [SHAPE_W-1:0]  shape,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam logic [SCAN_W-1:0] LAST_IDX = SCAN_W'(TILE_SIZE - 1);

    logic [1:0]          state, nxt_state;
    logic [SHAPE_W-1:0]  req_shape;
    logic [X_W-1:0]      req_x, prev_x;
    logic [Y_W-1:0]      req_y, prev_y;
    logic [COLOUR_W-1:0] req_colour;
    logic                req_ok, prev_valid;

    logic [SCAN_W-1:0]   row, col, next_row, next_col, emit_row, emit_col;
    logic                last, scan_clear, scan_en;
    logic                start_ok, erase_needed, latch, store_prev;
    logic                emit, emit_erase, nxt_plot, nxt_done;
    logic [X_W-1:0]      nxt_x, tile_x;
    logic [Y_W-1:0]      nxt_y, tile_y;
    logic [COLOUR_W-1:0] nxt_colour, colour_sel;
    logic [SHAPE_W-1:0]  shape_sel;

    tile_scan_counter u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (scan_clear),
        .enable (scan_en),
        .row    (row),
        .col    (col),
        .last   (last)
    );

    assign start_ok     = (x_in <= X_W'(MAX_TILE_X)) && (y_in <= Y_W'(MAX_TILE_Y));
    assign erase_needed = prev_valid && ((x_in != prev_x) || (y_in != prev_y));
    assign next_col     = (col == LAST_IDX) ? '0 : col + SCAN_W'(1);
    assign next_row     = (col == LAST_IDX) ? row + SCAN_W'(1) : row;

    // Outputs are registered from the pixel the next cycle will show, so the
    // first plot appears the cycle after start and FINISH shows no plot.
    always_comb begin
        nxt_state  = state;
        scan_clear = 1'b0;
        scan_en    = 1'b0;
        latch      = 1'b0;
        store_prev = 1'b0;
        emit       = 1'b0;
        emit_erase = 1'b0;
        emit_row   = '0;
        emit_col   = '0;
        nxt_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                scan_clear = 1'b1;
                if (start) begin
                    latch = 1'b1;
                    if (!start_ok) begin
                        nxt_state = ST_FINISH;
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_state  = erase_needed ? ST_ERASE : ST_DRAW;
                        emit       = 1'b1;
                        emit_erase = erase_needed;
                    end
                end
            end
            ST_ERASE: begin
                emit = 1'b1;
                if (last) begin
                    scan_clear = 1'b1;
                    nxt_state  = ST_DRAW;
                end else begin
                    scan_en    = 1'b1;
                    emit_erase = 1'b1;
                    emit_row   = next_row;
                    emit_col   = next_col;
                end
            end
            ST_DRAW: begin
                if (last) begin
                    scan_clear = 1'b1;
                    nxt_state  = ST_FINISH;
                    nxt_done   = 1'b1;
                end else begin
                    scan_en  = 1'b1;
                    emit     = 1'b1;
                    emit_row = next_row;
                    emit_col = next_col;
                end
            end
            ST_FINISH: begin
                scan_clear = 1'b1;
                store_prev = req_ok;
                nxt_state  = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase

        tile_x     = emit_erase ? prev_x : ((state == ST_IDLE) ? x_in : req_x);
        tile_y     = emit_erase ? prev_y : ((state == ST_IDLE) ? y_in : req_y);
        shape_sel  = (state == ST_IDLE) ? shape : req_shape;
        colour_sel = (state == ST_IDLE) ? colour_in : req_colour;

        nxt_plot   = emit;
        nxt_x      = vga_x;
        nxt_y      = vga_y;
        nxt_colour = vga_colour;
        if (emit) begin
            nxt_x      = X_W'(pixel_coord(tile_x, emit_col));
            nxt_y      = Y_W'(pixel_coord(X_W'(tile_y), emit_row));
            nxt_colour = (!emit_erase && shape_sel[shape_index(emit_row, emit_col)])
                         ? colour_sel : BG_COLOUR;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= BG_COLOUR;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            req_shape  <= '0;
            req_x      <= '0;
            req_y      <= '0;
            req_colour <= '0;
            req_ok     <= 1'b0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
        end else begin
            state      <= nxt_state;
            vga_x      <= nxt_x;
            vga_y      <= nxt_y;
            vga_colour <= nxt_colour;
            plot       <= nxt_plot;
            busy       <= (nxt_state != ST_IDLE);
            done       <= nxt_done;
            if (latch) begin
                req_shape  <= shape;
                req_x      <= x_in;
                req_y      <= y_in;
                req_colour <= colour_in;
                req_ok     <= start_ok;
            end
            if (store_prev) begin
                prev_x     <= req_x;
                prev_y     <= req_y;
                prev_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pacman_sprite_drawer.sv
// Self-checking bench: directed vector table, randomized requests against a tile model, corner sequences.
module tb_pacman_sprite_drawer;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [24:0] shape;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  colour_in;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot, busy, done;

    pacman_sprite_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .shape      (shape),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: last drawn tile plus the expected pixel list of a request.
    bit          m_prev_valid = 1'b0;
    int          m_prev_x = 0;
    int          m_prev_y = 0;
    logic [17:0] exp_q[$];

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [24:0] sh;
        logic [2:0]  c;
        int          n;
        logic [17:0] first;
        logic [17:0] last;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_request(input logic [7:0] x, input logic [6:0] y,
                                 input logic [24:0] sh, input logic [2:0] c);
        int xi, yi;
        xi = int'(x);
        yi = int'(y);
        exp_q.delete();
        if (xi <= 31 && yi <= 23) begin
            if (m_prev_valid && (xi != m_prev_x || yi != m_prev_y))
                for (int r = 0; r < 5; r++)
                    for (int k = 0; k < 5; k++)
                        exp_q.push_back({8'(m_prev_x * 5 + k), 7'(m_prev_y * 5 + r), 3'b000});
            for (int r = 0; r < 5; r++)
                for (int k = 0; k < 5; k++)
                    exp_q.push_back({8'(xi * 5 + k), 7'(yi * 5 + r),
                                     sh[r * 5 + k] ? c : 3'b000});
            m_prev_valid = 1'b1;
            m_prev_x     = xi;
            m_prev_y     = yi;
        end
    endtask

    task automatic run_request(input logic [7:0] x, input logic [6:0] y, input logic [24:0] sh,
                               input logic [2:0] c, input int poke, output int nplots,
                               output logic [17:0] first, output logic [17:0] last);
        int n;
        logic [17:0] pix;
        model_request(x, y, sh, c);
        n = exp_q.size();
        @(negedge clock);
        x_in = x; y_in = y; shape = sh; colour_in = c; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        x_in = 8'($urandom_range(0, 31)); y_in = 7'($urandom_range(0, 23));
        shape = 25'($urandom); colour_in = 3'($urandom);
        nplots = 0; first = '0; last = '0;
        for (int cyc = 1; cyc <= n + 1; cyc++) begin
            start = (poke != 0 && cyc == poke);
            check("ctl busy/plot/done", {29'd0, busy, plot, done},
                  {29'd0, 1'b1, 1'(cyc <= n), 1'(cyc == n + 1)});
            if (plot) begin
                pix = {vga_x, vga_y, vga_colour};
                if (nplots < n) check("pixel", {14'd0, pix}, {14'd0, exp_q[nplots]});
                if (nplots == 0) first = pix;
                last = pix;
                nplots++;
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        check("idle after done", {29'd0, busy, plot, done}, 32'd0);
    endtask

    initial begin
        int np, cnt;
        logic [17:0] f, l;
        logic [7:0]  rx;
        logic [6:0]  ry;

        vecs[0] = '{8'd13, 7'd18, 25'h1FFFFFF, 3'b110, 25, {8'd65, 7'd90, 3'b110}, {8'd69, 7'd94, 3'b110}};
        vecs[1] = '{8'd13, 7'd18, 25'h0000001, 3'b110, 25, {8'd65, 7'd90, 3'b110}, {8'd69, 7'd94, 3'b000}};
        vecs[2] = '{8'd14, 7'd18, 25'h1FFFFFF, 3'b101, 50, {8'd65, 7'd90, 3'b000}, {8'd74, 7'd94, 3'b101}};
        vecs[3] = '{8'd32, 7'd0,  25'h1FFFFFF, 3'b111, 0,  18'd0, 18'd0};
        vecs[4] = '{8'd14, 7'd18, 25'h1000000, 3'b011, 25, {8'd70, 7'd90, 3'b000}, {8'd74, 7'd94, 3'b011}};
        vecs[5] = '{8'd31, 7'd23, 25'h1FFFFFF, 3'b111, 50, {8'd70, 7'd90, 3'b000}, {8'd159, 7'd119, 3'b111}};

        reset = 1'b1; start = 1'b0; shape = '0; x_in = '0; y_in = '0; colour_in = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset outputs", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
        check("reset ctl", {29'd0, busy, plot, done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_request(vecs[i].x, vecs[i].y, vecs[i].sh, vecs[i].c, 0, np, f, l);
            check("vec plot count", np, vecs[i].n);
            if (vecs[i].n > 0) begin
                check("vec first pixel", {14'd0, f}, {14'd0, vecs[i].first});
                check("vec last pixel", {14'd0, l}, {14'd0, vecs[i].last});
            end
        end

        for (int i = 0; i < 40; i++) begin
            if (m_prev_valid && $urandom_range(0, 3) == 0) begin
                rx = 8'(m_prev_x); ry = 7'(m_prev_y);
            end else begin
                rx = 8'($urandom_range(0, 34)); ry = 7'($urandom_range(0, 26));
            end
            run_request(rx, ry, 25'($urandom), 3'($urandom), 0, np, f, l);
            check("random plot count", np, exp_q.size());
        end

        // start pulsed mid-DRAW on a draw-only request must be dropped, not queued
        run_request(8'(m_prev_x), 7'(m_prev_y), 25'h0AAAAAA, 3'b001, 12, np, f, l);
        check("poke plot count", np, 25);
        repeat (2) begin
            @(posedge clock); #1;
            check("poke not queued", {30'd0, busy, plot}, 32'd0);
        end

        // reset at the tenth plot aborts the request and forgets the previous tile
        @(negedge clock);
        x_in = 8'd2; y_in = 7'd3; shape = 25'h1FFFFFF; colour_in = 3'b100; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cnt = 0;
        for (int cyc = 0; cyc < 60 && cnt < 10; cyc++) begin
            if (plot) cnt++;
            if (cnt < 10) begin
                @(posedge clock); #1;
            end
        end
        check("reached plot 10", cnt, 10);
        reset = 1'b1;
        #1;
        check("reset mid-draw ctl", {29'd0, busy, plot, done}, 32'd0);
        check("reset mid-draw pixel", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        m_prev_valid = 1'b0;
        run_request(8'd7, 7'd3, 25'($urandom), 3'b010, 0, np, f, l);
        check("no erase after reset", np, 25);
        check("first after reset", {14'd0, f[17:3]}, {17'd0, 8'd35, 7'd15});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pacman_sprite_drawer.md
PACMAN_SPRITE_DRAWER -- requirements
Module: pacman_sprite_drawer

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: one-cycle draw request, sampled in IDLE only.
REQ-004 The block SHALL have the port shape, input, 25 bits: 5x5 sprite bitmap; bit index = row*5 + col, bit 0 = top-left.
REQ-005 The block SHALL have the port x_in, input, 8 bits: tile column.
REQ-006 The block SHALL have the port y_in, input, 7 bits: tile row.
REQ-007 The block SHALL have the port colour_in, input, 3 bits: foreground RGB.
REQ-008 The block SHALL have the port vga_x, output, 8 bits: pixel x to VGA adapter, registered.
REQ-009 The block SHALL have the port vga_y, output, 7 bits: pixel y to VGA adapter, registered.
REQ-010 The block SHALL have the port vga_colour, output, 3 bits: pixel colour, registered.
REQ-011 The block SHALL have the port plot, output, 1 bit: pixel write strobe, registered.
REQ-012 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have the port done, output, 1 bit: one-cycle pulse when a request completes or is rejected.

Function
REQ-014 The FSM SHALL have the states IDLE, ERASE, DRAW and FINISH; the encoding SHALL be taken from the shared package.
REQ-015 In IDLE, start=1 SHALL latch shape, x_in, y_in and colour_in into request registers.
REQ-016 A request with x_in>31 or y_in>23 SHALL be rejected: next state FINISH, zero plots, done pulses, previous position unchanged.
REQ-017 A valid request SHALL go to ERASE if prev_valid=1 and (x_in,y_in) differs from the stored previous position; otherwise it SHALL go to DRAW.
REQ-018 ERASE SHALL issue 25 consecutive plot cycles covering the previous tile with vga_colour=000.
REQ-019 DRAW SHALL issue 25 consecutive plot cycles covering the latched tile, with vga_colour=colour_in where the shape bit is 1 and 000 where it is 0.
REQ-020 In both ERASE and DRAW, pixel x SHALL be tile_x*5+col and pixel y SHALL be tile_y*5+row.
REQ-021 Scan order in ERASE and DRAW SHALL be row-major: col 0..4 inner, row 0..4 outer.
REQ-022 Pixel arithmetic SHALL be done at 9/8 bits internally and SHALL not overflow for valid tiles (max pixel 159,119).
REQ-023 The first plot SHALL occur in the cycle after the one in which start is sampled.
REQ-024 DRAW-only requests SHALL produce exactly 25 plot cycles, then one FINISH cycle with done=1.
REQ-025 Requests that include ERASE SHALL produce exactly 50 plot cycles with no gap between ERASE and DRAW.
REQ-026 FINISH SHALL store the drawn position as the previous position, set prev_valid=1, and return to IDLE.
REQ-027 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-028 Changes to shape, x_in, y_in or colour_in after start is latched SHALL NOT affect the request in flight.
REQ-029 plot SHALL be 0 in IDLE and FINISH.

Reset
REQ-030 Reset SHALL force state=IDLE.
REQ-031 Reset SHALL force vga_x=0, vga_y=0, vga_colour=000, plot=0, busy=0 and done=0.
REQ-032 Reset SHALL force prev_valid=0 and clear the scan counters.
REQ-033 Reset mid-ERASE or mid-DRAW SHALL abort the request with no further plots; the next request SHALL skip ERASE.

Structure
REQ-034 The shared package SHALL hold TILE_SIZE=5, MAX_TILE_X=31, MAX_TILE_Y=23, BG_COLOUR=000 and the state encoding.
REQ-035 The 5x5 row/col scanner SHALL be a sub-module named tile_scan_counter with inputs clear and enable and outputs row, col and last.

Verification
REQ-036 After reset, start with x=13, y=18, shape=all ones, colour=110 SHALL produce 25 plots from (65,90) to (69,94), all colour 110, then done with no erase.
REQ-037 Repeating the same position with shape=0x0000001 SHALL produce 25 plots only, colour 110 at (65,90) and 000 elsewhere.
REQ-038 Moving to (14,18) SHALL produce 25 erase plots at (65..69,90..94) colour 000, then 25 draw plots at (70..74,90..94); total 50 plots plus 1 done.
REQ-039 start with x=32, y=0 SHALL produce 0 plots, done 1 cycle after start, and leave the previous position unchanged.
REQ-040 start pulsed during DRAW SHALL have no effect (plot count unchanged); reset asserted at plot 10 SHALL give plot=0 immediately, and the next request SHALL issue no erase.
REQ-041 Tile (31,23) SHALL have last pixel (159,119) with no wrap.
